// File: rtl/cpu_pkg.sv
// Shared CPU-side definitions: cache FSM states, DataWidth codes, store lane helpers.
package cpu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FILL  = 2'd1,
    ST_WRITE = 2'd2,
    ST_IO    = 2'd3
  } state_e;

  localparam logic [2:0] DW_W  = 3'b000;
  localparam logic [2:0] DW_H  = 3'b001;
  localparam logic [2:0] DW_B  = 3'b010;
  localparam logic [2:0] DW_HU = 3'b101;
  localparam logic [2:0] DW_BU = 3'b100;

  // Byte enables for a store; misaligned halves/words truncate to their natural lanes.
  function automatic logic [3:0] byte_en(input logic [2:0] dw, input logic [1:0] off);
    logic [3:0] be;
    case (dw)
      DW_W:        be = 4'b1111;
      DW_H, DW_HU: be = off[1] ? 4'b1100 : 4'b0011;
      DW_B, DW_BU: be = 4'b0001 << off;
      default:     be = 4'b1111;
    endcase
    return be;
  endfunction

  // Move right-aligned store data into the byte lanes selected by the address.
  function automatic logic [31:0] store_lanes(input logic [2:0] dw, input logic [1:0] off,
                                              input logic [31:0] wd);
    logic [31:0] r;
    case (dw)
      DW_W:        r = wd;
      DW_H, DW_HU: r = off[1] ? {wd[15:0], 16'h0000} : {16'h0000, wd[15:0]};
      DW_B, DW_BU: r = {24'h000000, wd[7:0]} << {off, 3'b000};
      default:     r = wd;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/load_extract.sv
// Selects the byte/half addressed by off and sign- or zero-extends it per DataWidth.
module load_extract
  import cpu_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  off,
  input  logic [2:0]  dw,
  output logic [31:0] data_c
);

  logic [7:0]  sel_b;
  logic [15:0] sel_h;

  // Lane select then extend; unknown codes return the whole word.
  always_comb begin
    sel_b = word[{off, 3'b000} +: 8];
    sel_h = off[1] ? word[31:16] : word[15:0];
    case (dw)
      DW_W:    data_c = word;
      DW_B:    data_c = {{24{sel_b[7]}}, sel_b};
      DW_BU:   data_c = {24'h000000, sel_b};
      DW_H:    data_c = {{16{sel_h[15]}}, sel_h};
      DW_HU:   data_c = {16'h0000, sel_h};
      default: data_c = word;
    endcase
  end

endmodule

// File: rtl/dcache.sv
// Direct-mapped, one-word-line, write-through/no-allocate data cache with an uncached IO window.
module dcache
  import cpu_pkg::*;
#(
  parameter int unsigned SETS    = 64,
  parameter logic [31:0] IO_BASE = 32'hBFC01000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        wen,
  input  logic        ren,
  input  logic [2:0]  DataWidth,
  output logic [31:0] dout,
  output logic        stall,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack
);

  localparam int unsigned IDX_W = $clog2(SETS);
  localparam int unsigned TAG_W = 32 - IDX_W - 2;

  state_e            state_q, state_d;
  logic [SETS-1:0]   valid_q, valid_d;
  logic              done_q, done_d;
  logic [31:0]       io_q, io_d;
  logic [TAG_W-1:0]  tag_q [SETS];
  logic [31:0]       data_q [SETS];

  logic [IDX_W-1:0]  idx;
  logic [TAG_W-1:0]  tag;
  logic              cached, hit_line, ld, st;
  logic [31:0]       line, lanes, merged, hit_ext, io_ext;
  logic [3:0]        be;
  logic              arr_we;
  logic [31:0]       arr_wdata;

  assign idx      = addr[IDX_W+1:2];
  assign tag      = addr[31:IDX_W+2];
  assign cached   = (addr < IO_BASE);
  assign line     = data_q[idx];
  assign hit_line = valid_q[idx] && (tag_q[idx] == tag);
  assign st       = wen;
  assign ld       = ren && !wen;
  assign be       = byte_en(DataWidth, addr[1:0]);
  assign lanes    = store_lanes(DataWidth, addr[1:0], wdata);

  load_extract u_hit_ext (.word(line), .off(addr[1:0]), .dw(DataWidth), .data_c(hit_ext));
  load_extract u_io_ext  (.word(io_q), .off(addr[1:0]), .dw(DataWidth), .data_c(io_ext));

  // Store-hit merge: enabled bytes come from the store, the rest from the line.
  always_comb begin
    merged = line;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) merged[8*i +: 8] = lanes[8*i +: 8];
    end
  end

  // Next state, array write controls and CPU/memory outputs.
  always_comb begin
    state_d   = state_q;
    valid_d   = valid_q;
    done_d    = 1'b0;
    io_d      = io_q;
    arr_we    = 1'b0;
    arr_wdata = line;
    stall     = 1'b0;
    dout      = 32'h0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = {addr[31:2], 2'b00};
    mem_wdata = 32'h0;
    mem_be    = 4'b1111;
    case (state_q)
      ST_IDLE: begin
        // done_q marks the retire cycle of a store or IO load whose inputs are still held
        if (done_q && ld && !cached) begin
          dout = io_ext;
        end else if (done_q && st) begin
          stall = 1'b0;
        end else if (st) begin
          stall   = 1'b1;
          state_d = ST_WRITE;
        end else if (ld && !cached) begin
          stall   = 1'b1;
          state_d = ST_IO;
        end else if (ld && hit_line) begin
          dout = hit_ext;
        end else if (ld) begin
          stall   = 1'b1;
          state_d = ST_FILL;
        end
      end
      ST_FILL: begin
        stall   = 1'b1;
        mem_req = 1'b1;
        if (mem_ack) begin
          arr_we       = 1'b1;
          arr_wdata    = mem_rdata;
          valid_d[idx] = 1'b1;
          state_d      = ST_IDLE;
        end
      end
      ST_IO: begin
        stall   = 1'b1;
        mem_req = 1'b1;
        if (mem_ack) begin
          io_d    = mem_rdata;
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      ST_WRITE: begin
        stall     = 1'b1;
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_wdata = lanes;
        mem_be    = be;
        if (mem_ack) begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
          if (cached && hit_line) begin
            arr_we    = 1'b1;
            arr_wdata = merged;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Control registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      valid_q <= '0;
      done_q  <= 1'b0;
      io_q    <= 32'h0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      done_q  <= done_d;
      io_q    <= io_d;
    end
  end

  // Tag/data arrays; never written while reset is asserted.
  always_ff @(posedge clk) begin
    if (rst_n && arr_we) begin
      tag_q[idx]  <= tag;
      data_q[idx] <= arr_wdata;
    end
  end

endmodule

// File: doc/dcache.md
DCACHE -- requirements
Module: dcache

Interface
REQ-001 SHALL have parameter SETS, default 64, number of direct-mapped one-word lines (power of two).
REQ-002 SHALL have parameter IO_BASE, default 32'hBFC01000; addresses >= IO_BASE are uncached.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  synchronous active-low reset, sampled on rising clk.
REQ-005 SHALL have CPU-side ports:
- addr  input  32  byte address
- wdata  input  32  store data, right-aligned
- wen  input  1  store request
- ren  input  1  load request
- DataWidth  input  3  000 W, 001 H, 010 B, 101 HU, 100 BU
- dout  output  32  load result, extended per DataWidth
- stall  output  1  CPU must hold all inputs while high
REQ-006 SHALL have memory-side ports:
- mem_req  output  1
- mem_we  output  1
- mem_addr  output  32  word-aligned
- mem_wdata  output  32
- mem_be  output  4
- mem_rdata  input  32
- mem_ack  input  1  one-cycle completion pulse

Function
REQ-007 SHALL index by addr[log2(SETS)+1:2]; tag is the remaining upper address bits; each line has one valid bit.
REQ-008 SHALL treat a cached load with matching tag and valid as a hit: dout valid combinationally in the same cycle, stall=0.
REQ-009 SHALL extract the byte/half at addr[1:0] (half at addr[1]); sign-extend for B/H, zero-extend for BU/HU; undefined codes behave as W.
REQ-010 SHALL implement FSM IDLE, FILL, WRITE, IO.
- IDLE->FILL: cached load miss.
- IDLE->WRITE: any wen.
- IDLE->IO: uncached load.
REQ-011 SHALL drive stall=1 combinationally in the IDLE cycle a miss, store or IO load is detected, and in every non-IDLE cycle.
REQ-012 In FILL SHALL hold mem_req=1, mem_we=0, mem_be=4'b1111, mem_addr={addr[31:2],2'b00}.
- On mem_ack: write mem_rdata, tag and valid=1 into the line; go to IDLE.
- The next cycle hits.
REQ-013 In IO SHALL issue the FILL transaction without updating the array.
- On mem_ack: capture mem_rdata into a register; go to IDLE.
- The next cycle returns the extracted register value with stall=0 (one-shot bypass; no re-fetch).
REQ-014 Stores SHALL be write-through, no write-allocate.
- In WRITE: mem_req=1, mem_we=1, wdata lane-shifted to addr[1:0].
- mem_be: 1111 for W, 0011/1100 for H, one-hot for B.
- On mem_ack: go to IDLE; stall deasserts the following cycle.
REQ-015 On a store hit, SHALL merge the enabled bytes into the cached line on the mem_ack edge; a store miss SHALL leave the array unchanged; uncached stores never touch the array.
REQ-016 When wen and ren are both high, SHALL treat the access as a store only.
REQ-017 SHALL hold mem_addr, mem_wdata, mem_be, mem_we stable while mem_req=1; mem_req SHALL drop in the cycle after mem_ack.
REQ-018 mem_ack while in IDLE SHALL be ignored.
REQ-019 Misaligned W/H accesses are unsupported; the byte lanes used SHALL be those given by addr[1:0] truncation.

Reset
REQ-020 On rst_n=0 at a rising edge, SHALL clear all valid bits, enter IDLE, and drive mem_req=0, mem_we=0, stall=0, dout=0 until the next access.
REQ-021 Reset during FILL/WRITE/IO SHALL abandon the transaction with no array update; a later mem_ack SHALL be ignored.
REQ-022 Data and tag arrays need no reset.

Structure
REQ-023 SHALL place the FSM state enum and the DataWidth encodings in shared package cpu_pkg.
REQ-024 SHALL use sub-module load_extract (combinational lane select plus sign/zero-extend), shared by the hit and IO paths.

Verification
REQ-025 Reset, then LW 0x00010000 with memory word 0x11223344: one FILL, ack, then dout=0x11223344 with stall=0; a repeat load hits with no mem_req.
REQ-026 After REQ-025, LB 0x00010003 -> dout=0x00000011; memory 0x000100F0 word 0x80FF7F00 with LH 0x000100F2 -> 0xFFFF80FF; LHU 0x000100F2 -> 0x000080FF.
REQ-027 SB 0x00010001 with wdata 0xAA on a valid line -> mem_be=0010, mem_wdata[15:8]=0xAA; a following LW hits and returns 0x1122AA44.
REQ-028 LW 0xFFFFFFFC -> IO path with mem_req; the next cycle returns mem_rdata with no array allocation; a repeat load issues mem_req again.
REQ-029 Assert rst_n=0 mid-FILL, then pulse mem_ack -> state IDLE, line invalid, mem_req=0; a subsequent load of the same address misses.
REQ-030 wen and ren both high on address 0x00010000 -> WRITE only; mem_we=1 and no FILL.
